// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time into LSB-first UART frames
// (start, data, optional even parity, one stop bit).
//
// state  | meaning
// IDLE   | line high, waiting for EN and a non-empty FIFO
// FETCH  | RD strobe to the FIFO
// LOAD   | FIFO data valid, captured into shift register at closing edge
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even parity bit (PARITY_EN=1 only)
// STOP   | stop bit (high), DONE in its last cycle
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  EN,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic                  RD,
  output logic                  TX,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t                state, state_nxt;
  logic [BW-1:0]         baud_cnt, baud_nxt;
  logic [CW-1:0]         bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic                  par, par_nxt;
  logic                  tx_q, tx_nxt;
  logic                  bit_tick;

  assign bit_tick = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      par      <= par_nxt;
      tx_q     <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    par_nxt   = par;
    case (state)
      IDLE:  if (EN && !EMPTY) state_nxt = FETCH;
      FETCH: state_nxt = LOAD;
      LOAD: begin
        shift_nxt = dataIn;
        par_nxt   = ^dataIn;
        baud_nxt  = '0;
        bit_nxt   = '0;
        state_nxt = START;
      end
      START: begin
        if (bit_tick) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (bit_tick) begin
          baud_nxt  = '0;
          shift_nxt = shift >> 1;
          if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
            bit_nxt   = '0;
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + CW'(1);
          end
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      PARITY: begin
        if (bit_tick) begin
          baud_nxt  = '0;
          state_nxt = STOP;
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (bit_tick) begin
          baud_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level is computed from the next state so TX comes straight off a flop.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  assign TX   = tx_q;
  assign RD   = (state == FETCH);
  assign BUSY = (state != IDLE);
  assign DONE = (state == STOP) && bit_tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance without parity, one with,
// both at 4 clocks per bit, each fed by a small FIFO model.
module tb_fifo_uart_tx;

  logic       Clk;
  logic       Rst_n;
  logic       en0, en1;
  logic       empty0 = 1'b1;
  logic       empty1 = 1'b1;
  logic [7:0] din0 = '0;
  logic [7:0] din1 = '0;
  logic       RD0, TX0, BUSY0, DONE0;
  logic       RD1, TX1, BUSY1, DONE1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdcnt0 = 0, rdcnt1 = 0, rd_cyc0 = 0, dbl = 0;
  logic rd_prev0 = 1'b0, rd_prev1 = 1'b0;

  logic sel;
  logic tx_s, done_s;
  assign tx_s   = sel ? TX1 : TX0;
  assign done_s = sel ? DONE1 : DONE0;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .EN(en0), .EMPTY(empty0), .dataIn(din0),
    .RD(RD0), .TX(TX0), .BUSY(BUSY0), .DONE(DONE0)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .EN(en1), .EMPTY(empty1), .dataIn(din1),
    .RD(RD1), .TX(TX1), .BUSY(BUSY1), .DONE(DONE1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // FIFO models: read data appears the cycle after RD, empty flag tracks the queue.
  always @(posedge Clk) begin
    if (RD0 && q0.size() > 0) din0 <= q0.pop_front();
    empty0 <= (q0.size() == 0);
    if (RD1 && q1.size() > 0) din1 <= q1.pop_front();
    empty1 <= (q1.size() == 0);
  end

  always @(negedge Clk) begin
    rd_prev0 <= RD0;
    rd_prev1 <= RD1;
    if (RD0) begin
      rdcnt0  <= rdcnt0 + 1;
      rd_cyc0 <= cyc;
    end
    if (RD1) rdcnt1 <= rdcnt1 + 1;
    if ((RD0 && rd_prev0) || (RD1 && rd_prev1)) dbl <= dbl + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_fall(input string tag, output int c);
    int n;
    n = 0;
    while (tx_s !== 1'b0 && n < 400) begin
      @(negedge Clk);
      n++;
    end
    c = cyc;
    chk({tag, "_fall"}, 32'(tx_s), 32'd0);
  endtask

  task automatic frame(input string tag, input int nb, input logic [15:0] exp);
    logic [15:0] bits;
    int glitch, dcnt, dlast;
    bits = '0; glitch = 0; dcnt = 0; dlast = 0;
    for (int k = 0; k < nb * 4; k++) begin
      if (k > 0) @(negedge Clk);
      if (k % 4 == 0) bits[k/4] = tx_s;
      else if (tx_s !== bits[k/4]) glitch++;
      if (done_s === 1'b1) begin
        dcnt++;
        if (k == nb * 4 - 1) dlast = 1;
      end
    end
    chk({tag, "_bits"}, 32'(bits), 32'(exp));
    chk({tag, "_glitch"}, 32'(glitch), 32'd0);
    chk({tag, "_done_cnt"}, 32'(dcnt), 32'd1);
    chk({tag, "_done_last"}, 32'(dlast), 32'd1);
  endtask

  task automatic gap(input string tag, input int exp);
    int n;
    n = 0;
    @(negedge Clk);
    while (tx_s === 1'b1 && n < 60) begin
      n++;
      @(negedge Clk);
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    int errs, n, ce, cf, r0, r1;
    Rst_n = 1'b0; en0 = 1'b1; en1 = 1'b1; sel = 1'b0;

    // reset values
    repeat (3) @(negedge Clk);
    chk("rst_tx0", 32'(TX0), 32'd1);
    chk("rst_rd0", 32'(RD0), 32'd0);
    chk("rst_busy0", 32'(BUSY0), 32'd0);
    chk("rst_done0", 32'(DONE0), 32'd0);
    chk("rst_tx1", 32'(TX1), 32'd1);
    chk("rst_busy1", 32'(BUSY1), 32'd0);
    Rst_n = 1'b1;

    // idle with empty FIFO
    errs = 0;
    repeat (50) begin
      @(negedge Clk);
      if (TX0 !== 1'b1 || RD0 !== 1'b0 || BUSY0 !== 1'b0 || DONE0 !== 1'b0) errs++;
      if (TX1 !== 1'b1 || RD1 !== 1'b0 || BUSY1 !== 1'b0 || DONE1 !== 1'b0) errs++;
    end
    chk("idle_50", 32'(errs), 32'd0);

    // single frame 0xA5
    r0 = rdcnt0;
    q0.push_back(8'hA5);
    n = 0;
    while (empty0 !== 1'b0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("a5_empty", 32'(empty0), 32'd0);
    ce = cyc;
    wait_fall("a5", cf);
    chk("a5_fall_lat", 32'(cf - ce), 32'd3);
    chk("a5_rd_lat", 32'(rd_cyc0 - ce), 32'd1);
    frame("a5", 10, 16'h34A);
    repeat (10) @(negedge Clk);
    chk("a5_rd_cnt", 32'(rdcnt0 - r0), 32'd1);
    chk("a5_busy_after", 32'(BUSY0), 32'd0);

    // parity frames 0x07 (par 1) and 0xA5 (par 0), back to back
    sel = 1'b1;
    r1 = rdcnt1;
    q1.push_back(8'h07);
    q1.push_back(8'hA5);
    wait_fall("p07", cf);
    frame("p07", 11, 16'h60E);
    gap("p_gap", 3);
    frame("pa5", 11, 16'h54A);
    repeat (10) @(negedge Clk);
    chk("p_rd_cnt", 32'(rdcnt1 - r1), 32'd2);
    sel = 1'b0;

    // back-to-back 0x01 0x02 0x03
    r0 = rdcnt0;
    q0.push_back(8'h01);
    q0.push_back(8'h02);
    q0.push_back(8'h03);
    wait_fall("b1", cf);
    frame("b1", 10, 16'h202);
    gap("b_gap1", 3);
    frame("b2", 10, 16'h204);
    gap("b_gap2", 3);
    frame("b3", 10, 16'h206);
    repeat (30) @(negedge Clk);
    chk("b_rd_cnt", 32'(rdcnt0 - r0), 32'd3);
    chk("b_empty", 32'(empty0), 32'd1);
    chk("b_busy_after", 32'(BUSY0), 32'd0);

    // EN gating
    en0 = 1'b0;
    r0 = rdcnt0;
    q0.push_back(8'h55);
    q0.push_back(8'hF0);
    repeat (100) @(negedge Clk);
    chk("en_off_rd", 32'(rdcnt0 - r0), 32'd0);
    chk("en_off_busy", 32'(BUSY0), 32'd0);
    en0 = 1'b1;
    wait_fall("en55", cf);
    en0 = 1'b0;
    frame("en55", 10, 16'h2AA);
    repeat (40) @(negedge Clk);
    chk("en_drop_rd", 32'(rdcnt0 - r0), 32'd1);
    chk("en_drop_empty", 32'(empty0), 32'd0);
    chk("en_drop_busy", 32'(BUSY0), 32'd0);

    // reset during data bit 3 of 0xF0
    q0.push_back(8'h33);
    en0 = 1'b1;
    wait_fall("f0", cf);
    repeat (17) @(negedge Clk);
    chk("pre_rst_tx", 32'(TX0), 32'd0);
    chk("pre_rst_busy", 32'(BUSY0), 32'd1);
    #1 Rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(TX0), 32'd1);
    chk("mid_rst_busy", 32'(BUSY0), 32'd0);
    chk("mid_rst_rd", 32'(RD0), 32'd0);
    chk("mid_rst_done", 32'(DONE0), 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    wait_fall("post33", cf);
    frame("post33", 10, 16'h266);
    repeat (10) @(negedge Clk);
    chk("post_empty", 32'(empty0), 32'd1);
    chk("rd_never_double", 32'(dbl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
